uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one UART transmitter between `NUM_REQ` byte producers using round-robin arbitration. Accepts one byte per frame through a per-requester valid/ready handshake and drives the transmitter's `tx_data`/`tx_start_send` inputs. The transmitter has no busy output, so this block counts `baud_clk_en` ticks until the frame completes and only then grants the next requester. It sits directly in front of `uart_transmitter` and shares its `clk` and `baud_clk_en`.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters (2..16).
- `FRAME_TICKS`, default 11: `baud_clk_en` ticks from transmitter start until the transmitter is back in idle.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `baud_clk_en`  in  1  one-cycle baud tick, the same signal that feeds the transmitter.
- `req_valid`  in  NUM_REQ  bit i: requester i holds a byte.
- `req_data`  in  8*NUM_REQ  byte i is `[8i+7:8i]`.
- `req_ready`  out  NUM_REQ  bit i: byte i accepted this cycle.
- `tx_data`  out  8  byte to the transmitter (registered).
- `tx_start_send`  out  1  one-cycle start pulse to the transmitter (registered).
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `grant_id`  out  clog2(NUM_REQ)  index of the current or last granted requester (registered).
- `frame_done`  out  1  one-cycle pulse when the frame completes.

## Operation

The block is a four-state FSM.

- **IDLE**
  - `sel` is the first index with `req_valid` set, searching from `rr_ptr` upward and wrapping modulo NUM_REQ.
  - If any `req_valid` is set: `req_ready[sel]=1`, which is combinational and only in IDLE. The transfer completes on that edge.
  - On that edge: `tx_data<=req_data[sel]`, `grant_id<=sel`, `tick_cnt<=0`, next state START.
  - All other `req_ready` bits are 0.
- **START**
  - `tx_start_send=1` for exactly this one cycle. Next state WAIT.
  - A `baud_clk_en` in this cycle is not counted.
- **WAIT**
  - Each `baud_clk_en` increments `tick_cnt`.
  - On a `baud_clk_en` with `tick_cnt==FRAME_TICKS-1`, next state DONE.
- **DONE**
  - `frame_done=1` for one cycle.
  - `rr_ptr<=(grant_id==NUM_REQ-1)?0:grant_id+1`.
  - Next state IDLE.

General rules:
- Requesters must hold `req_valid` and `req_data` stable until `req_ready` is seen. Dropping `req_valid` before grant is legal: the request is simply not served.
- `req_ready` is never asserted while `rst` is high, or in any state other than IDLE.
- `tx_data` and `grant_id` hold their values from the START state until the next grant.
- `tick_cnt` width is clog2(FRAME_TICKS+1). It never wraps.
- A `req_valid` change during START, WAIT or DONE has no effect until IDLE.

## Timing

- Reset values:
  - State IDLE, `rr_ptr=0`, `tick_cnt=0`.
  - `tx_data=8'h00`, `tx_start_send=0`, `grant_id=0`, `frame_done=0`, `busy=0`, `req_ready=0`.
- Latency:
  - Grant edge (valid&ready) to `tx_start_send` high: 1 cycle.
  - `tx_start_send` to `frame_done`: cycles to reach the FRAME_TICKS-th counted tick, plus 1.
- Back-to-back: IDLE follows DONE, so the next grant happens at the earliest 1 cycle after `frame_done`. The transmitter is already idle at that point.
- Fairness: a requester that stays valid is served within NUM_REQ frames.
- Reset mid-frame: the FSM returns to IDLE immediately and the pending frame is abandoned. `rst` must also reset the transmitter.

## Structure

- Shared package `uart_pkg`:
  - FSM state encoding (`ARB_IDLE`, `ARB_START`, `ARB_WAIT`, `ARB_DONE`, 2 bits).
  - `UART_FRAME_TICKS=11` constant, used as the default for `FRAME_TICKS`.
- Sub-module `rr_picker`: combinational. Takes `req_valid[NUM_REQ]` and `rr_ptr` and produces `sel` and `any_valid`, implemented as a double-width mask search. It is reusable by other arbiters.
- The top level holds the FSM, counter, registered outputs and data mux.

## Test plan

1. **Single request:** reset, then `req_valid=4'b0100` with `req_data[23:16]=8'hA5`.
   - Expect `req_ready=4'b0100` for 1 cycle, then `tx_start_send` for 1 cycle with `tx_data=8'hA5` and `grant_id=2`.
   - Expect `frame_done` after 11 counted ticks, then `rr_ptr=3`.
2. **Simultaneous requests:** `req_valid=4'b1111` held, refreshed after each ready.
   - Expect grant order 0,1,2,3,0 with exactly one `req_ready` bit per frame.
3. **Wrap-around:** `rr_ptr=3` after frame 1, then `req_valid=4'b1001`.
   - Expect grant 3, then 0.
4. **Tick in START not counted:** assert `baud_clk_en` in the START cycle, then 11 more ticks.
   - Expect `frame_done` only after the 11th tick in WAIT.
   - Expect no `req_ready` during `busy`, even with `req_valid=4'b1111`.
5. **Reset mid-WAIT:** assert `rst` after 5 ticks.
   - Expect `busy=0`, `tx_start_send=0`, `grant_id=0`, `rr_ptr=0` asynchronously.
   - After release with `req_valid=4'b0010`, expect grant 1 in the first cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM encoding and
// the default frame length in baud ticks.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_START = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

    // Start bit + 8 data bits + stop bit + one tick to settle back in idle.
    localparam int UART_FRAME_TICKS = 11;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and transmitter-facing signals of the UART TX arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_start_send;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;
    logic                 frame_done;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_data, tx_start_send, busy, grant_id, frame_done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_data, tx_start_send, busy, grant_id, frame_done
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index at or above rr_ptr,
// wrapping, found by searching a doubled request vector.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [ID_W-1:0]    sel_o,
    output logic               any_valid_o
);

    logic [2*NUM_REQ-1:0] hits;
    logic                 found;

    // The lower copy is masked below rr_ptr; the upper copy provides the wrap.
    always_comb begin
        hits  = {req_valid_i, req_valid_i};
        sel_o = '0;
        found = 1'b0;
        for (int i = 0; i < 2*NUM_REQ; i++) begin
            if (i < int'(rr_ptr_i)) hits[i] = 1'b0;
        end
        for (int i = 0; i < 2*NUM_REQ; i++) begin
            if (hits[i] && !found) begin
                sel_o = ID_W'(i % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign any_valid_o = |req_valid_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; the frame length is tracked by
// counting baud ticks because the transmitter exposes no busy flag.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_TICKS = UART_FRAME_TICKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_clk_en,
    uart_tx_arbiter_if.slave  bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FRAME_TICKS + 1);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic                tx_start_q, tx_start_d;
    logic                frame_done_q, frame_done_d;
    logic [NUM_REQ-1:0]  ready_d;
    logic [ID_W-1:0]     sel;
    logic                any_valid;

    rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
        .req_valid_i (bus.req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .sel_o       (sel),
        .any_valid_o (any_valid)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        tick_cnt_d   = tick_cnt_q;
        tx_data_d    = tx_data_q;
        grant_d      = grant_q;
        tx_start_d   = 1'b0;
        frame_done_d = 1'b0;
        ready_d      = '0;
        case (state_q)
            ARB_IDLE: begin
                if (any_valid) begin
                    ready_d[sel] = 1'b1;
                    tx_data_d    = bus.req_data[8*sel +: 8];
                    grant_d      = sel;
                    tick_cnt_d   = '0;
                    tx_start_d   = 1'b1;
                    state_d      = ARB_START;
                end
            end
            ARB_START: state_d = ARB_WAIT;
            ARB_WAIT: begin
                if (baud_clk_en) begin
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    if (tick_cnt_q == CNT_W'(FRAME_TICKS - 1)) begin
                        state_d      = ARB_DONE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            ARB_DONE: begin
                rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                state_d  = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            tick_cnt_q   <= '0;
            tx_data_q    <= 8'h00;
            grant_q      <= '0;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            tick_cnt_q   <= tick_cnt_d;
            tx_data_q    <= tx_data_d;
            grant_q      <= grant_d;
            tx_start_q   <= tx_start_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.req_ready     = rst ? '0 : ready_d;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_start_send = tx_start_q;
    assign bus.busy          = (state_q != ARB_IDLE);
    assign bus.grant_id      = grant_q;
    assign bus.frame_done    = frame_done_q;

endmodule
